// File: rtl/mux_4_to_1_pkg.sv
// mux_4_to_1_pkg: shared select-code definitions for the four-way selector.
package mux_4_to_1_pkg;

  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_IN0 = 2'b00;
  localparam sel_t SEL_IN1 = 2'b01;
  localparam sel_t SEL_IN2 = 2'b10;
  localparam sel_t SEL_IN3 = 2'b11;

endpackage

// File: rtl/mux_4_to_1_core.sv
// mux_4_to_1_core: purely combinational four-way selector over packed inputs.
// Input k occupies in[k*WIDTH +: WIDTH]. An unknown select yields X so that
// select problems stay visible in simulation.
module mux_4_to_1_core
  import mux_4_to_1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [4*WIDTH-1:0] in,
  input  sel_t               sel,
  output logic [WIDTH-1:0]   out
);

  // Route the selected slice; the default branch only fires for X/Z selects.
  always_comb begin
    case (sel)
      SEL_IN0: out = in[0*WIDTH +: WIDTH];
      SEL_IN1: out = in[1*WIDTH +: WIDTH];
      SEL_IN2: out = in[2*WIDTH +: WIDTH];
      SEL_IN3: out = in[3*WIDTH +: WIDTH];
      default: out = {WIDTH{1'bx}};
    endcase
  end

endmodule

// File: rtl/mux_4_to_1.sv
// mux_4_to_1: four-way selector with an optional registered copy of the
// result and a select-change strobe.
// Build option: define MUX_4_TO_1_OUT_REG_EN to include the registered stage.
// Without it, out_q follows out combinationally and sel_chg is held at 0;
// clk, rst_n and en remain ports but are ignored.
module mux_4_to_1
  import mux_4_to_1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4*WIDTH-1:0] in,
  input  sel_t               sel,
  input  logic               en,
  output logic [WIDTH-1:0]   out,
  output logic [WIDTH-1:0]   out_q,
  output logic               sel_chg
);

  mux_4_to_1_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .in (in),
    .sel(sel),
    .out(out)
  );

`ifdef MUX_4_TO_1_OUT_REG_EN

  logic [WIDTH-1:0] data_q, data_d;
  sel_t             sel_q, sel_d;
  logic             chg_q, chg_d;

  // Next state: capture on enable, otherwise hold data/select and drop strobe.
  always_comb begin
    data_d = data_q;
    sel_d  = sel_q;
    chg_d  = 1'b0;
    if (en) begin
      data_d = out;
      sel_d  = sel;
      chg_d  = (sel != sel_q);
    end
  end

  // Registered stage with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      sel_q  <= SEL_IN0;
      chg_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      sel_q  <= sel_d;
      chg_q  <= chg_d;
    end
  end

  assign out_q   = data_q;
  assign sel_chg = chg_q;

`else

  // Clock, reset and enable have no function in this build.
  logic unused_ports;
  assign unused_ports = ^{clk, rst_n, en};

  assign out_q   = out;
  assign sel_chg = 1'b0;

`endif

endmodule

// File: tb/tb_mux_4_to_1.sv
// tb_mux_4_to_1: exercises a WIDTH=1 and a WIDTH=8 instance side by side with
// shared select/enable/reset. A driver pushes expected responses computed
// from a shift-based reference model; a negedge monitor pops and compares.
module tb_mux_4_to_1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic [1:0]  sel   = 2'b00;
  logic [3:0]  in1   = '0;
  logic [31:0] in8   = '0;

  logic        out1, q1, chg1;
  logic [7:0]  out8, q8;
  logic        chg8;

  mux_4_to_1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in(in1), .sel(sel), .en(en),
    .out(out1), .out_q(q1), .sel_chg(chg1)
  );

  mux_4_to_1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in(in8), .sel(sel), .en(en),
    .out(out8), .out_q(q8), .sel_chg(chg8)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic       o1;
    logic       q1;
    logic [7:0] o8;
    logic [7:0] q8;
    logic       chg;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Registered-stage model state.
  logic       m_q1    = 1'b0;
  logic [7:0] m_q8    = '0;
  logic [1:0] m_sel_q = 2'b00;
  logic       m_chg   = 1'b0;

  function automatic logic pick1(logic [3:0] v, logic [1:0] s);
    logic [3:0] t;
    t = v >> s;
    return t[0];
  endfunction

  function automatic logic [7:0] pick8(logic [31:0] v, logic [1:0] s);
    logic [31:0] t;
    t = v >> (8 * int'(s));
    return t[7:0];
  endfunction

  // ---------------- driver ----------------
  // One call = one clock cycle: advance the model over the edge using the
  // inputs that were applied, then apply new inputs and push the expectation
  // for the following negedge.
  task automatic step(input logic r, input logic e, input logic [1:0] s,
                      input logic [3:0] i1, input logic [31:0] i8);
    exp_t x;
    @(posedge clk);
    if (!rst_n) begin
      m_q1 = 1'b0; m_q8 = '0; m_sel_q = 2'b00; m_chg = 1'b0;
    end else if (en) begin
      m_chg   = (sel != m_sel_q);
      m_q1    = pick1(in1, sel);
      m_q8    = pick8(in8, sel);
      m_sel_q = sel;
    end else begin
      m_chg = 1'b0;
    end
    #2;
    rst_n = r; en = e; sel = s; in1 = i1; in8 = i8;
    if (!r) begin
      m_q1 = 1'b0; m_q8 = '0; m_sel_q = 2'b00; m_chg = 1'b0;
    end
    x.o1 = pick1(i1, s);
    x.o8 = pick8(i8, s);
`ifdef MUX_4_TO_1_OUT_REG_EN
    x.q1  = m_q1;
    x.q8  = m_q8;
    x.chg = m_chg;
`else
    x.q1  = x.o1;
    x.q8  = x.o8;
    x.chg = 1'b0;
`endif
    exp_q.push_back(x);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      chk("out_w1",     {7'b0, out1}, {7'b0, x.o1});
      chk("out_q_w1",   {7'b0, q1},   {7'b0, x.q1});
      chk("sel_chg_w1", {7'b0, chg1}, {7'b0, x.chg});
      chk("out_w8",     out8,         x.o8);
      chk("out_q_w8",   q8,           x.q8);
      chk("sel_chg_w8", {7'b0, chg8}, {7'b0, x.chg});
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [31:0] WORDS = {8'hDD, 8'hCC, 8'hBB, 8'hAA};

  initial begin
    // Reset held low: registers must read zero.
    step(1'b0, 1'b0, 2'b00, 4'b1010, WORDS);
    step(1'b0, 1'b1, 2'b11, 4'b1010, WORDS);

    // Static inputs, select walked 0..3 with the register stage disabled.
    for (int s = 0; s < 4; s++) step(1'b1, 1'b0, 2'(s), 4'b1010, WORDS);

    // Enabled: settle on sel=00, then move to 10 with in=0100.
    step(1'b1, 1'b1, 2'b00, 4'b0100, WORDS);
    step(1'b1, 1'b1, 2'b00, 4'b0100, WORDS);
    step(1'b1, 1'b1, 2'b10, 4'b0100, WORDS);
    step(1'b1, 1'b1, 2'b10, 4'b0100, WORDS); // out_q=1, sel_chg=1
    step(1'b1, 1'b1, 2'b10, 4'b0100, WORDS); // sel_chg back to 0

    // Disabled while inputs move: registered outputs hold, strobe stays low.
    step(1'b1, 1'b0, 2'b01, 4'b0001, 32'h1234_5678);
    step(1'b1, 1'b0, 2'b11, 4'b0111, 32'h9ABC_DEF0);
    step(1'b1, 1'b0, 2'b00, 4'b1110, 32'h0F0F_0F0F);
    // Re-enable and observe capture.
    step(1'b1, 1'b1, 2'b11, 4'b1000, 32'h5500_0000);
    step(1'b1, 1'b1, 2'b11, 4'b1000, 32'h5500_0000);

    // Mid-operation reset while out_q=1: clears before the next edge.
    step(1'b1, 1'b1, 2'b10, 4'b0100, WORDS);
    step(1'b1, 1'b1, 2'b10, 4'b0100, WORDS);
    step(1'b0, 1'b1, 2'b01, 4'b0010, WORDS);
    step(1'b0, 1'b1, 2'b11, 4'b1000, WORDS);
    // Release: first enabled edge with sel=00 gives no strobe.
    step(1'b1, 1'b1, 2'b00, 4'b0001, WORDS);
    step(1'b1, 1'b1, 2'b00, 4'b0001, WORDS);
    step(1'b1, 1'b1, 2'b01, 4'b0010, WORDS);

    // Randomized traffic with occasional resets and random enable.
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), 4'($urandom), 32'($urandom));
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_4_to_1.md
# mux_4_to_1

Four-input, one-output selector with an optional registered copy of the result. It drives the combinational output `out` directly from the input vector selected by `sel`. A clocked stage supplies a registered output and a select-change strobe for downstream synchronous consumers. Used as a leaf datapath primitive wherever one of four candidate bits or words is routed to a single consumer.

## Interface
- `WIDTH`, default 1: bit width of each of the four data inputs and of the outputs.
- `clk`  input  1  single clock; all registers update on the rising edge.
- `rst_n`  input  1  reset, asynchronous assert, active-low.
- `in`  input  4*WIDTH  four packed data inputs; `in[k*WIDTH +: WIDTH]` is input k (k = 0..3).
- `sel`  input  2  select code; value k routes input k.
- `en`  input  1  load enable for the registered stage.
- `out`  output  WIDTH  combinational selected data.
- `out_q`  output  WIDTH  registered selected data.
- `sel_chg`  output  1  one-cycle pulse when the registered `sel` differs from its previous registered value.

## Operation
- `out` = input[`sel`] at all times, purely combinational, independent of `clk`, `rst_n` and `en`.
- Encoding: 2'b00 routes in0, 2'b01 routes in1, 2'b10 routes in2, 2'b11 routes in3. There is no default or illegal code.
- X or Z on `sel` must not be masked. `out` is X in simulation.
- Registered stage, when `en`=1 at a rising edge:
  - `out_q` <= `out`
  - `sel_q` <= `sel`
  - `sel_chg` <= (`sel` != `sel_q`)
- When `en`=0, `out_q` and `sel_q` hold, and `sel_chg` <= 0.
- `sel_chg` is never high for two consecutive cycles unless `sel` changes on each enabled edge.

## Timing
- `out`: zero-cycle latency, combinational path from `in` and `sel` only.
- `out_q`: one-cycle latency from the edge at which `en`=1 samples `in`/`sel`.
- Reset values, asynchronous on `rst_n` falling, held while low: `out_q`=0, `sel_q`=2'b00, `sel_chg`=0.
- After `rst_n` deasserts, the first enabled edge with `sel`=2'b00 gives `sel_chg`=0. Any other `sel` gives `sel_chg`=1.
- Reset asserted mid-operation clears the registers immediately. `out` is unaffected.
- Simultaneous `in` and `sel` changes before the same edge: the edge captures the new combination.

## Configuration
- Macro `MUX_4_TO_1_OUT_REG_EN`.
- Defined: the registered stage is present exactly as specified above.
- Undefined:
  - No flops.
  - `out_q` is tied combinationally to `out`.
  - `sel_chg` is tied to 0.
  - `clk`, `rst_n` and `en` remain ports but are unused.
- `out` behaviour is identical in both builds.

## Structure
- Package `mux_4_to_1_pkg`:
  - `SEL_W` = 2.
  - Select-code localparams `SEL_IN0`..`SEL_IN3` = 2'b00..2'b11.
  - Typedef `sel_t` (logic [SEL_W-1:0]).
- Sub-module `mux_4_to_1_core`: parameterised combinational selector (`in`, `sel` -> `out`), instantiated once.
- The top level adds the conditional register stage.

## Test plan
- Static `in`=4'b1010 (WIDTH=1), no clock. Step `sel` 00, 01, 10, 11, holding each for 10 time units. Required `out` sequence: 0, 1, 0, 1.
- WIDTH=8, `in`={8'hDD,8'hCC,8'hBB,8'hAA}, step `sel` 0..3 -> `out` = AA, BB, CC, DD.
- Macro defined, `en`=1, `sel` goes 00 to 10 before an edge, `in`=4'b0100:
  - `out_q`=1 one cycle later.
  - `sel_chg`=1 for exactly one cycle.
  - Holding `sel` then gives `sel_chg`=0.
- Macro defined, `en`=0 while `sel`/`in` change: `out_q` holds its prior value and `sel_chg` stays 0. Re-enable and check capture on the next edge.
- Assert `rst_n`=0 between clock edges while `out_q`=1:
  - `out_q` and `sel_chg` go to 0 immediately, without waiting for an edge.
  - `out` keeps tracking `in`/`sel`.
- Macro undefined: `out_q` equals `out` combinationally for all 4 select codes, and `sel_chg` is constantly 0.
